key_event_queue: RTL
====================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter N_KEYS, default 8: number of debounced key inputs, fixed at 8 (3-bit index).
REQ-002 Parameter DEPTH, default 8: FIFO entries, power of two, 2..16.
REQ-003 Parameter REP_DELAY, default 24'd5_000_000: cycles from press event to first repeat event, minimum 2.
REQ-004 Parameter REP_RATE, default 24'd1_000_000: cycles between subsequent repeat events, minimum 2.
REQ-005 clk  in  1  system clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 keys  in  8  debounced key levels (1 = held), already synchronous to clk.
REQ-008 rd_en  in  1  pop request; ignored when empty.
REQ-009 clr_ovf  in  1  clears the overflow flag.
REQ-010 data  out  8  head event {type[1:0], 3'b000, idx[2:0]}; type 01 press, 10 release, 11 repeat.
REQ-011 valid  out  1  FIFO non-empty.
REQ-012 count  out  5  current FIFO occupancy, 0..DEPTH.
REQ-013 ovf  out  1  sticky overflow flag.

Function
REQ-014 Scanner: 3-bit index idx advances idx+1 (wrap 7->0) each cycle unless stalled; one key examined per cycle.
REQ-015 Scanner compares keys[idx] with stored prev[idx]; on difference it requests a press (0->1) or release (1->0) event for idx.
REQ-016 Scanner event is pushed and prev[idx] updated in the same cycle; worst-case latency from key change to push is 8 cycles.
REQ-017 Scanner stalls (idx and prev held) while it has a pending event that is not pushed; press/release events are never lost.
REQ-018 Repeat tracker: on push of a press for key k, held_idx<=k, held_v<=1, timer<=REP_DELAY-1.
REQ-019 On push of a release for key held_idx, held_v<=0; releases of other keys do not affect the tracker.
REQ-020 While held_v, timer decrements each cycle; at 0 a repeat event for held_idx is requested and timer reloads REP_RATE-1.
REQ-021 Repeat request is suppressed (timer still reloads) if keys[held_idx]==0 that cycle.
REQ-022 Arbitration: repeat request has priority over scanner in the same cycle; scanner stalls that cycle.
REQ-023 Repeat request that cannot be pushed (FIFO full, no pop) is dropped and sets ovf; it is not retried.
REQ-024 FIFO: circular buffer, write/read pointers log2(DEPTH) bits wrapping, count updated +1 push, -1 pop, unchanged both/neither.
REQ-025 Push allowed when count<DEPTH, or when count==DEPTH and rd_en pops in the same cycle.
REQ-026 Pop when rd_en && valid: read pointer advances; data is combinational from head entry (first-word fall-through).
REQ-027 Push into empty FIFO: valid and data visible the cycle after the push edge.
REQ-028 rd_en while empty: no effect, count stays 0, no underflow flag.
REQ-029 ovf set by REQ-023; clr_ovf clears it; set and clear in same cycle -> set wins.
REQ-030 Events leave the FIFO in push order.

Reset
REQ-031 rst low asynchronously: idx=0, prev=8'h00, held_v=0, timer=0, pointers=0, count=0, ovf=0; valid=0, data=8'h00 (empty FIFO drives 0).
REQ-032 Keys already high at reset release produce press events during the first scan pass.
REQ-033 Reset asserted mid-operation discards all queued events and pending repeats; no partial push.

Verification
REQ-034 keys=8'h04 after reset, no pops -> within 8 cycles count=1, data=8'h42; keys=0 -> second entry 8'h82.
REQ-035 REP_DELAY=10, REP_RATE=4, key 1 held -> press 8'h41, then 8'hC1 10 cycles after press push, then every 4 cycles; release -> 8'h81, no further repeats.
REQ-036 DEPTH=8, toggle keys without pops until count=8 -> scanner stalls, further changes kept; pop one -> stalled event pushed next cycle, ovf stays 0.
REQ-037 FIFO full with repeat due and no pop -> repeat dropped, ovf=1; clr_ovf pulse -> ovf=0.
REQ-038 Full FIFO, rd_en and push same cycle -> count stays 8, order preserved across pointer wrap.
REQ-039 rst pulsed low with count=5 and key held -> count=0, valid=0, ovf=0 immediately; after release held key re-reported as press.

Source files
------------

// File: rtl/key_event_queue.sv
// Key scanner with typematic repeat feeding an event FIFO.
// Events are {type[1:0], 3'b000, idx[2:0]} and leave in push order.
module key_event_queue #(
  parameter int          N_KEYS    = 8,
  parameter int          DEPTH     = 8,
  parameter logic [23:0] REP_DELAY = 24'd5_000_000,
  parameter logic [23:0] REP_RATE  = 24'd1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [7:0]        data,
  output logic              valid,
  output logic [4:0]        count,
  output logic              ovf
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
  localparam logic [1:0]  T_PRESS = 2'b01;
  localparam logic [1:0]  T_REL   = 2'b10;
  localparam logic [1:0]  T_REP   = 2'b11;

  logic [2:0]        idx_q, idx_d;
  logic [N_KEYS-1:0] prev_q, prev_d;
  logic              held_v_q, held_v_d;
  logic [2:0]        held_idx_q, held_idx_d;
  logic [23:0]       timer_q, timer_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     rp_q, rp_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];

  logic       pop;
  logic       can_push;
  logic       key_now;
  logic       scan_req;
  logic       rep_req;
  logic       scan_push;
  logic       rep_push;
  logic       push;
  logic [7:0] wr_data;

  always_comb begin
    pop       = rd_en && (cnt_q != 5'd0);
    can_push  = (cnt_q < DEPTH_C) || pop;
    key_now   = keys[idx_q];
    scan_req  = key_now != prev_q[idx_q];
    rep_req   = held_v_q && (timer_q == 24'd0) && keys[held_idx_q];
    scan_push = !rep_req && scan_req && can_push;
    rep_push  = rep_req && can_push;
    push      = scan_push || rep_push;
    if (rep_push) begin
      wr_data = {T_REP, 3'b000, held_idx_q};
    end else begin
      wr_data = {key_now ? T_PRESS : T_REL, 3'b000, idx_q};
    end
  end

  always_comb begin
    idx_d      = idx_q;
    prev_d     = prev_q;
    held_v_d   = held_v_q;
    held_idx_d = held_idx_q;
    timer_d    = timer_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    mem_d      = mem_q;

    // Scanner holds its place while a repeat owns the slot or the push is blocked
    if (!rep_req && (!scan_req || can_push)) begin
      idx_d = idx_q + 3'd1;
    end
    if (scan_push) begin
      prev_d[idx_q] = key_now;
    end

    if (scan_push && key_now) begin
      held_v_d   = 1'b1;
      held_idx_d = idx_q;
      timer_d    = REP_DELAY - 24'd1;
    end else if (scan_push && (idx_q == held_idx_q)) begin
      held_v_d = 1'b0;
    end else if (held_v_q) begin
      if (timer_q == 24'd0) begin
        timer_d = REP_RATE - 24'd1;
      end else begin
        timer_d = timer_q - 24'd1;
      end
    end

    if (push) begin
      mem_d[wp_q] = wr_data;
      wp_d        = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 5'd1;
      2'b01:   cnt_d = cnt_q - 5'd1;
      default: cnt_d = cnt_q;
    endcase

    // A dropped repeat outranks a clear in the same cycle
    if (rep_req && !can_push) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      prev_q     <= '0;
      held_v_q   <= 1'b0;
      held_idx_q <= '0;
      timer_q    <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      idx_q      <= idx_d;
      prev_q     <= prev_d;
      held_v_q   <= held_v_d;
      held_idx_q <= held_idx_d;
      timer_q    <= timer_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
    end
  end

  assign valid = cnt_q != 5'd0;
  assign data  = valid ? mem_q[rp_q] : 8'h00;
  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule
